mat_reader: RTL and testbench

MAT_READER -- requirements
Module: mat_reader

---
 rtl/mat_reader_pkg.sv | 15 +
 rtl/mat_elem_sel.sv | 19 +
 rtl/mat_reader.sv | 85 ++++++++
 tb/tb_mat_reader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mat_reader_pkg.sv
// Shared constants and FSM encoding for the matrix streaming reader.
package mat_reader_pkg;

    localparam int N        = 5;
    localparam int W        = 8;
    localparam int MAT_BITS = N * N * W;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mat_elem_sel.sv
// Picks one signed element out of a row-major packed matrix; element (0,0) sits in the top bits.
module mat_elem_sel #(
    parameter int N = mat_reader_pkg::N,
    parameter int W = mat_reader_pkg::W
) (
    input  logic [N*N*W-1:0]                 mat,
    input  logic [mat_reader_pkg::IDX_W-1:0] row,
    input  logic [mat_reader_pkg::IDX_W-1:0] col,
    output logic signed [W-1:0]              elem
);

    int idx;

    always_comb begin
        idx  = int'(row) * N + int'(col);
        elem = mat[(N*N-1-idx)*W +: W];
    end

endmodule

// File: rtl/mat_reader.sv
// Captures a packed NxN matrix on start and streams it element by element over a valid/ready port.
module mat_reader #(
    parameter int N = mat_reader_pkg::N,
    parameter int W = mat_reader_pkg::W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [N*N*W-1:0]                 m_in,
    input  logic                             ovf_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [W-1:0]              out_data,
    output logic [mat_reader_pkg::IDX_W-1:0] out_row,
    output logic [mat_reader_pkg::IDX_W-1:0] out_col,
    output logic                             out_last,
    output logic                             ovf_out,
    output logic                             busy,
    output logic                             done
);
    import mat_reader_pkg::*;

    state_t           state, state_nxt;
    logic [N*N*W-1:0] shadow;
    logic [IDX_W-1:0] row, col;
    logic             capture, xfer, at_last;

    assign at_last   = (row == IDX_W'(N-1)) && (col == IDX_W'(N-1));
    assign out_valid = (state == ST_SEND);
    assign busy      = out_valid;
    assign done      = (state == ST_DONE);
    assign out_last  = out_valid & at_last;
    assign out_row   = row;
    assign out_col   = col;
    assign capture   = (state == ST_IDLE) & start;
    assign xfer      = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)           state_nxt = ST_SEND;
            ST_SEND: if (xfer && at_last) state_nxt = ST_DONE;
            ST_DONE:                      state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    // Shadow copy is written only on capture, so upstream may change m_in freely mid-stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            ovf_out <= 1'b0;
            row     <= '0;
            col     <= '0;
        end else if (capture) begin
            shadow  <= m_in;
            ovf_out <= ovf_in;
            row     <= '0;
            col     <= '0;
        end else if (xfer) begin
            if (at_last) begin
                row <= '0;
                col <= '0;
            end else if (col == IDX_W'(N-1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    mat_elem_sel #(.N(N), .W(W)) u_sel (
        .mat  (shadow),
        .row  (row),
        .col  (col),
        .elem (out_data)
    );

endmodule

// File: tb/tb_mat_reader.sv
// Directed/randomised bench for mat_reader against a row-major element-list reference model.
module tb_mat_reader;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int NN = N * N;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [NN*W-1:0]     m_in;
    logic                ovf_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic [2:0]          out_row, out_col;
    logic                out_last, ovf_out, busy, done;

    logic signed [W-1:0] mdl [NN];
    int checks = 0;
    int errors = 0;

    mat_reader #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .m_in(m_in), .ovf_in(ovf_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .ovf_out(ovf_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NN*W-1:0] pack_model();
        logic [NN*W-1:0] v;
        v = '0;
        for (int i = 0; i < NN; i++) v[(NN-1-i)*W +: W] = mdl[i];
        return v;
    endfunction

    function automatic logic [NN*W-1:0] rand_mat();
        logic [NN*W-1:0] v;
        for (int i = 0; i < NN; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"},  out_data,  0);
        check({tag, "_row"},   out_row,   0);
        check({tag, "_col"},   out_col,   0);
        check({tag, "_last"},  out_last,  0);
        check({tag, "_ovf"},   ovf_out,   0);
        check({tag, "_busy"},  busy,      0);
        check({tag, "_done"},  done,      0);
    endtask

    // Present the model matrix, pulse start for one cycle, then scramble the inputs.
    task automatic launch(input bit ovf);
        m_in   = pack_model();
        ovf_in = ovf;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        m_in   = rand_mat();
        ovf_in = ~ovf;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic stream(input int mode, input bit exp_ovf, input int stop, input bit disturb,
                          output int got);
        int k   = 0;
        int cyc = 0;
        while (k < stop && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (disturb && k == 7) begin
                start = 1'b1;
                m_in  = rand_mat();
            end else begin
                start = 1'b0;
            end
            check("valid", out_valid, 1);
            check("data",  out_data,  mdl[k]);
            check("row",   out_row,   k / N);
            check("col",   out_col,   k % N);
            check("last",  out_last,  (k == NN-1));
            check("ovf",   ovf_out,   exp_ovf);
            check("busy",  busy,      1);
            check("done_early", done, 0);
            if (out_ready) k++;
            tick();
            cyc++;
        end
        start = 1'b0;
        if (k < stop) check("stream_timeout", k, stop);
        got = cyc;
    endtask

    task automatic tail(input bit start_in_done);
        check("done_pulse",  done,      1);
        check("done_valid",  out_valid, 0);
        check("done_busy",   busy,      0);
        start = start_in_done;
        m_in  = rand_mat();
        tick();
        start = 1'b0;
        check("done_clear",  done,      0);
        check("idle_valid",  out_valid, 0);
        check("idle_busy",   busy,      0);
        tick();
        check("idle_valid2", out_valid, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; m_in = rand_mat(); ovf_in = 1'b1; out_ready = 1'b0;
        #1;
        check_idle_zero("reset");
        tick();
        rst = 1'b0;
        tick();
        check_idle_zero("post_reset");

        // Elements 1..25, full throughput
        for (int i = 0; i < NN; i++) mdl[i] = W'(i + 1);
        launch(1'b0);
        stream(0, 1'b0, NN, 1'b0, cyc);
        check("consecutive_cycles", cyc, NN);
        tail(1'b1);

        // Extreme values in row 0 with overflow flag
        for (int i = 0; i < NN; i++) mdl[i] = W'($urandom);
        mdl[0] = 8'sd127; mdl[1] = -8'sd128; mdl[2] = -8'sd1; mdl[3] = 8'sd0; mdl[4] = 8'sd50;
        launch(1'b1);
        check("hex_0_0", out_data, 32'hFFFF_FF7F & {{24{1'b0}}, 8'h7F});
        stream(0, 1'b1, NN, 1'b0, cyc);
        tail(1'b0);

        // Stalling ready pattern 1,0,0,1
        for (int i = 0; i < NN; i++) mdl[i] = W'($urandom);
        launch(1'($urandom));
        stream(1, ovf_out, NN, 1'b0, cyc);
        tail(1'b0);

        // Random ready with new data and a second start mid-stream
        for (int i = 0; i < NN; i++) mdl[i] = W'($urandom);
        launch(1'b1);
        stream(2, 1'b1, NN, 1'b1, cyc);
        tail(1'b0);

        // Reset after 10 transfers
        for (int i = 0; i < NN; i++) mdl[i] = W'($urandom);
        launch(1'b1);
        stream(0, 1'b1, 10, 1'b0, cyc);
        rst = 1'b1;
        #1;
        check_idle_zero("midreset");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("no_done_after_reset", done, 0);
            tick();
        end
        for (int i = 0; i < NN; i++) mdl[i] = W'($urandom);
        launch(1'b0);
        stream(2, 1'b0, NN, 1'b0, cyc);
        tail(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
